bcd_serial_adder: RTL and testbench

Digit-serial multi-digit BCD adder. It accepts two packed NDIGITS-digit BCD operands plus a carry-in over a valid/ready handshake. It adds them one decimal digit per clock, least-significant digit first, through a single-digit BCD adder cell with a registered inter-digit carry. It then presents the packed BCD sum, the decimal carry-out and an invalid-digit flag over a second valid/ready handshake. It sits between an operand source (keypad/register file) and result consumers (display, accumulator).

---
 rtl/bcd_serial_adder_pkg.sv | 18 +
 rtl/bcd_serial_adder_digit_cell.sv | 28 ++
 rtl/bcd_serial_adder.sv | 130 +++++++++++++
 tb/tb_bcd_serial_adder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_adder_pkg.sv
// Shared constants, FSM state type and digit-validity helper for the
// digit-serial BCD adder.
package bcd_serial_adder_pkg;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_bad_digit(input logic [BCD_DIGIT_W-1:0] d);
    return (d > BCD_DIGIT_W'(BCD_MAX_DIGIT));
  endfunction

endpackage

// File: rtl/bcd_serial_adder_digit_cell.sv
// Combinational single-digit BCD adder: binary sum, then +6 correction
// when the sum exceeds 9.
module bcd_digit_cell
  import bcd_serial_adder_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  input  logic [BCD_DIGIT_W-1:0] b,
  input  logic                   cin,
  output logic [BCD_DIGIT_W-1:0] s,
  output logic                   cout
);

  logic [BCD_DIGIT_W:0] raw;
  logic [BCD_DIGIT_W:0] fixed;

  always_comb begin
    raw   = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
    fixed = raw + (BCD_DIGIT_W+1)'(6);
    if (raw > (BCD_DIGIT_W+1)'(BCD_MAX_DIGIT)) begin
      s    = fixed[BCD_DIGIT_W-1:0];
      cout = 1'b1;
    end else begin
      s    = raw[BCD_DIGIT_W-1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder, one digit per clock LSD first,
// with valid/ready handshakes on operands and result.
//
// state | meaning
// IDLE  | waiting for an operand bundle, in_ready=1
// RUN   | adding digit idx, carry held in carry_reg
// DONE  | result presented, out_valid=1 until out_ready
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BCD_DIGIT_W*NDIGITS-1:0] in_a,
  input  logic [BCD_DIGIT_W*NDIGITS-1:0] in_b,
  input  logic                           in_cin,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BCD_DIGIT_W*NDIGITS-1:0] out_sum,
  output logic                           out_cout,
  output logic                           out_err
);

  localparam int W    = BCD_DIGIT_W * NDIGITS;
  localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

  state_t state, next_state;

  logic [W-1:0]           a_reg, b_reg, sum_reg;
  logic                   carry_reg, err_reg;
  logic [IDXW-1:0]        idx;
  logic [BCD_DIGIT_W-1:0] cell_a, cell_b, cell_s;
  logic                   cell_cout;
  logic                   op_err;

  always_comb begin
    op_err = 1'b0;
    for (int d = 0; d < NDIGITS; d++) begin
      if (is_bad_digit(in_a[BCD_DIGIT_W*d +: BCD_DIGIT_W]) ||
          is_bad_digit(in_b[BCD_DIGIT_W*d +: BCD_DIGIT_W]))
        op_err = 1'b1;
    end
  end

  // Digit mux written with constant selects so NDIGITS=1 stays in range.
  always_comb begin
    cell_a = '0;
    cell_b = '0;
    for (int d = 0; d < NDIGITS; d++) begin
      if (idx == IDXW'(d)) begin
        cell_a = a_reg[BCD_DIGIT_W*d +: BCD_DIGIT_W];
        cell_b = b_reg[BCD_DIGIT_W*d +: BCD_DIGIT_W];
      end
    end
  end

  bcd_digit_cell u_cell (
    .a    (cell_a),
    .b    (cell_b),
    .cin  (carry_reg),
    .s    (cell_s),
    .cout (cell_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (idx == LAST_IDX) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      err_reg   <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= in_cin;
            sum_reg   <= '0;
            idx       <= '0;
            err_reg   <= op_err;
          end
        end
        RUN: begin
          for (int d = 0; d < NDIGITS; d++) begin
            if (idx == IDXW'(d)) sum_reg[BCD_DIGIT_W*d +: BCD_DIGIT_W] <= cell_s;
          end
          carry_reg <= cell_cout;
          if (idx != LAST_IDX) idx <= idx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = sum_reg;
  assign out_cout = carry_reg;
  assign out_err  = err_reg;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: directed operands with literal
// expectations plus a decimal scoreboard checked every cycle out_valid is high.
module tb_bcd_serial_adder;

  localparam int ND = 4;
  localparam int W  = 4 * ND;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_cin;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_cout, out_err;
  logic [W-1:0] out_sum;

  int checks = 0;
  int errors = 0;

  logic [W+1:0] expq[$];

  bcd_serial_adder #(.NDIGITS(ND)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal model: treat each nibble as a digit value, add column by column.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [W-1:0] s;
    int c, da, db, t;
    logic er;
    s  = '0;
    c  = int'(cin);
    er = 1'b0;
    for (int d = 0; d < ND; d++) begin
      da = int'(a[4*d +: 4]);
      db = int'(b[4*d +: 4]);
      if (da > 9 || db > 9) er = 1'b1;
      t = da + db + c;
      if (t > 9) begin
        s[4*d +: 4] = 4'((t + 6) % 16);
        c = 1;
      end else begin
        s[4*d +: 4] = 4'(t);
        c = 0;
      end
    end
    return {er, (c == 1), s};
  endfunction

  // Scoreboard: sample mid-cycle, push on accept, check and pop on result.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        expq.delete();
      end else begin
        if (in_valid && in_ready) expq.push_back(model(in_a, in_b, in_cin));
        if (out_valid) begin
          check("sb_ready_low", {31'd0, in_ready}, 32'd0);
          if (expq.size() == 0) begin
            check("sb_unexpected_valid", 32'd1, 32'd0);
          end else begin
            check("sb_sum",  {16'd0, out_sum},  {16'd0, expq[0][W-1:0]});
            check("sb_cout", {31'd0, out_cout}, {31'd0, expq[0][W]});
            check("sb_err",  {31'd0, out_err},  {31'd0, expq[0][W+1]});
            if (out_ready) void'(expq.pop_front());
          end
        end
      end
    end
  end

  // Caller must be at a negedge; returns at a negedge with in_ready expected high.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [W-1:0] es, input logic ec, input logic ee,
                       input int hold);
    int cnt;
    bit got;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    check("ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        got = 1;
        break;
      end
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check("valid_timeout", {31'd0, got}, 32'd1);
    check("latency", cnt, ND);
    check("sum",  {16'd0, out_sum},  {16'd0, es});
    check("cout", {31'd0, out_cout}, {31'd0, ec});
    check("err",  {31'd0, out_err},  {31'd0, ee});
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      in_a = W'($urandom);
      in_b = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_ready", {31'd0, in_ready},  32'd0);
      check("hold_sum",   {16'd0, out_sum},   {16'd0, es});
      check("hold_cout",  {31'd0, out_cout},  {31'd0, ec});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("ready_after_release", {31'd0, in_ready},  32'd1);
    check("valid_after_release", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, in_ready},  32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum",   {16'd0, out_sum},   32'd0);
    check("rst_cout",  {31'd0, out_cout},  32'd0);
    check("rst_err",   {31'd0, out_err},   32'd0);
    rst_n = 1'b1;

    // Pin the model against hand-computed results.
    check("model_a", {14'd0, model(16'h1234, 16'h5678, 1'b0)}, {14'd0, 2'b00, 16'h6912});
    check("model_b", {14'd0, model(16'h9999, 16'h9999, 1'b1)}, {14'd0, 2'b01, 16'h9999});
    check("model_c", {14'd0, model(16'h00A0, 16'h0000, 1'b0)}, {14'd0, 2'b10, 16'h0100});

    do_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 0);
    do_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'h0999, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0, 0);
    do_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 5);
    do_op(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1, 0);
    do_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 2);

    // Reset during the second RUN cycle.
    in_a = 16'h5555; in_b = 16'h5555; in_cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_ready", {31'd0, in_ready},  32'd1);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_sum",   {16'd0, out_sum},   32'd0);
    check("mid_rst_cout",  {31'd0, out_cout},  32'd0);
    check("mid_rst_err",   {31'd0, out_err},   32'd0);
    do_op(16'h4321, 16'h5678, 1'b1, 16'h0000, 1'b1, 1'b0, 1);
    do_op(16'h0F00, 16'h0100, 1'b0, 16'h1600, 1'b0, 1'b1, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
